// File: rtl/mul_nbit_wallace_pipe.sv
// Three-stage pipelined signed/unsigned multiplier: partial products, Wallace
// carry-save reduction with bit-level full adders, then a final carry-propagate add.
module mul_nbit_wallace_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_sgn,
  input  logic                  i_clr,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [RES_WIDTH-1:0]  o_res
);

  // One extra row carries the +1 that completes negation of the signed top row.
  localparam int NR   = DATA_WIDTH + 1;
  localparam int LVLS = 8;

  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  function automatic int rows_at(input int lvl);
    int r;
    r = NR;
    for (int l = 0; l < lvl; l++) begin
      r = r - (r / 3);
    end
    return r;
  endfunction

  logic                 stall_s;
  logic                 v1_q, v2_q, v3_q;
  logic                 v1_d, v2_d, v3_d;
  logic [RES_WIDTH-1:0] a_ext_s;
  logic [RES_WIDTH-1:0] pp_s [NR];
  logic [RES_WIDTH-1:0] pp_q [NR];
  logic [RES_WIDTH-1:0] sum_s, cy_s;
  logic [RES_WIDTH-1:0] sum_q, cy_q;
  logic [RES_WIDTH-1:0] res_q;

  assign stall_s = v3_q & ~i_rdy;
  assign o_rdy   = ~stall_s;
  assign o_vld   = v3_q;
  assign o_res   = res_q;

  // Partial products; signed mode subtracts the top row as ~row + 1.
  always_comb begin
    a_ext_s = {{(RES_WIDTH-DATA_WIDTH){i_sgn & i_num_a[DATA_WIDTH-1]}}, i_num_a};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (!i_num_b[i]) begin
        pp_s[i] = {RES_WIDTH{1'b0}};
      end else if (i_sgn && (i == DATA_WIDTH - 1)) begin
        pp_s[i] = ~(a_ext_s << i);
      end else begin
        pp_s[i] = a_ext_s << i;
      end
    end
    pp_s[NR-1] = {{(RES_WIDTH-1){1'b0}}, i_sgn & i_num_b[DATA_WIDTH-1]};
  end

  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    localparam int RC = rows_at(l);
    localparam int NG = RC / 3;
    logic [RES_WIDTH-1:0] in_s  [NR];
    logic [RES_WIDTH-1:0] out_s [NR];

    if (l == 0) begin : g_first
      always_comb in_s = pp_q;
    end else begin : g_next
      always_comb in_s = g_lvl[l-1].out_s;
    end

    // Each group of three rows becomes a sum row and a shifted carry row.
    always_comb begin
      logic [1:0]           fa_r;
      logic [RES_WIDTH-1:0] cy_w;
      fa_r = 2'b00;
      cy_w = {RES_WIDTH{1'b0}};
      for (int r = 0; r < NR; r++) begin
        out_s[r] = {RES_WIDTH{1'b0}};
      end
      for (int g = 0; g < NG; g++) begin
        for (int k = 0; k < RES_WIDTH; k++) begin
          fa_r = fa(in_s[3*g][k], in_s[3*g+1][k], in_s[3*g+2][k]);
          out_s[2*g][k] = fa_r[0];
          cy_w[k]       = fa_r[1];
        end
        out_s[2*g+1] = cy_w << 1;
      end
      for (int r = 3 * NG; r < RC; r++) begin
        out_s[r-NG] = in_s[r];
      end
    end
  end

  assign sum_s = g_lvl[LVLS-1].out_s[0];
  assign cy_s  = g_lvl[LVLS-1].out_s[1];

  // Valid bits: flush beats stall, stall freezes, otherwise shift.
  always_comb begin
    if (i_clr) begin
      {v1_d, v2_d, v3_d} = 3'b000;
    end else if (stall_s) begin
      {v1_d, v2_d, v3_d} = {v1_q, v2_q, v3_q};
    end else begin
      {v1_d, v2_d, v3_d} = {i_vld, v1_q, v2_q};
    end
  end

  // Stage registers; data only moves when the pipe is not stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      for (int r = 0; r < NR; r++) begin
        pp_q[r] <= {RES_WIDTH{1'b0}};
      end
      sum_q <= {RES_WIDTH{1'b0}};
      cy_q  <= {RES_WIDTH{1'b0}};
      res_q <= {RES_WIDTH{1'b0}};
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (!stall_s) begin
        pp_q  <= pp_s;
        sum_q <= sum_s;
        cy_q  <= cy_s;
        res_q <= sum_q + cy_q;
      end
    end
  end

endmodule

// File: tb/tb_mul_nbit_wallace_pipe.sv
// Bench for mul_nbit_wallace_pipe: directed vectors with literal expectations plus a
// queue-based arithmetic model checked on every falling edge.
module tb_mul_nbit_wallace_pipe;
  localparam int DW = 8;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_vld = 1'b0;
  logic          i_sgn = 1'b0;
  logic          i_clr = 1'b0;
  logic          i_rdy = 1'b1;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          o_rdy, o_vld;
  logic [RW-1:0] o_res;

  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q[$];

  mul_nbit_wallace_pipe #(.DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vld(i_vld), .o_rdy(o_rdy),
    .i_num_a(a), .i_num_b(b), .i_sgn(i_sgn), .i_clr(i_clr),
    .o_vld(o_vld), .i_rdy(i_rdy), .o_res(o_res)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                          input logic s);
    longint px, py;
    if (s) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
    end else begin
      px = longint'(x);
      py = longint'(y);
    end
    return RW'(px * py);
  endfunction

  task automatic check16(input string name, input logic [RW-1:0] act, input logic [RW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic checki(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Scoreboard: check outputs against the model, then apply this cycle's transfers.
  always @(negedge clk) begin
    if (!rst_n) begin
      check1("rst_vld", o_vld, 1'b0);
      check16("rst_res", o_res, 16'h0000);
      check1("rst_rdy", o_rdy, 1'b1);
      exp_q.delete();
    end else begin
      check1("rdy_rule", o_rdy, !(o_vld && !i_rdy));
      if (o_vld) begin
        if (exp_q.size() == 0) check1("spurious_vld", o_vld, 1'b0);
        else                   check16("model_res", o_res, exp_q[0]);
      end
      if (i_clr) begin
        exp_q.delete();
      end else begin
        if (o_vld && i_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (i_vld && !(o_vld && !i_rdy)) exp_q.push_back(model(a, b, i_sgn));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Caller is just after a rising edge with an empty pipe; checks exact 3-cycle latency.
  task automatic run_one(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic s,
                         input logic [RW-1:0] req, input string name);
    i_vld = 1'b1; a = x; b = y; i_sgn = s;
    sync();
    i_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) begin
        check1({name, "_early"}, o_vld, 1'b0);
      end else begin
        check1({name, "_vld"}, o_vld, 1'b1);
        check16(name, o_res, req);
      end
    end
  endtask

  initial begin
    int nv, first, last, n;
    logic [RW-1:0] got [3];

    i_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_rdy = 1'b1;

    run_one(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff");
    sync(); run_one(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_ff_ff");
    sync(); run_one(8'h80, 8'h80, 1'b1, 16'h4000, "s_80_80");
    sync(); run_one(8'h80, 8'h01, 1'b1, 16'hFF80, "s_80_01");
    sync(); run_one(8'h7F, 8'h80, 1'b1, 16'hC080, "s_7f_80");
    sync(); run_one(8'hFF, 8'h01, 1'b0, 16'h00FF, "u_ff_01");
    sync(); run_one(8'h01, 8'hFF, 1'b1, 16'hFFFF, "s_01_ff");

    nv = 0; first = -1; last = -1;
    for (int c = 0; c < 14; c++) begin
      sync();
      i_vld = (c < 8); a = 8'(c); b = 8'(c + 1); i_sgn = c[0];
      @(negedge clk);
      check1("stream_rdy", o_rdy, 1'b1);
      if (o_vld) begin
        nv++;
        if (first < 0) first = c;
        last = c;
      end
    end
    checki("stream_count", nv, 8);
    checki("stream_first", first, 3);
    checki("stream_contig", last - first + 1, 8);

    sync(); i_rdy = 1'b0; i_vld = 1'b1; a = 8'd3;   b = 8'd5;   i_sgn = 1'b0;
    sync();                              a = 8'h80; b = 8'h02; i_sgn = 1'b1;
    sync();                              a = 8'd200; b = 8'd100; i_sgn = 1'b0;
    sync();                              a = 8'd9;  b = 8'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("stall_rdy", o_rdy, 1'b0);
      check1("stall_vld", o_vld, 1'b1);
      check16("stall_res", o_res, 16'h000F);
      if (i < 4) sync();
    end
    sync(); i_vld = 1'b0; i_rdy = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (o_vld) begin
        if (n < 3) got[n] = o_res;
        n++;
      end
      sync();
    end
    checki("stall_drain_count", n, 3);
    check16("stall_out0", got[0], 16'h000F);
    check16("stall_out1", got[1], 16'hFF00);
    check16("stall_out2", got[2], 16'h4E20);

    i_vld = 1'b1; a = 8'd10; b = 8'd11; i_sgn = 1'b0;
    sync(); a = 8'hF0; b = 8'h0F; i_sgn = 1'b1;
    sync(); i_clr = 1'b1; a = 8'd5; b = 8'd5;
    sync(); i_clr = 1'b0; i_vld = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check1("clr_no_vld", o_vld, 1'b0);
      sync();
    end
    run_one(8'h12, 8'h34, 1'b0, 16'h03A8, "after_clr");

    sync(); i_vld = 1'b1; a = 8'd7;   b = 8'd7;   i_sgn = 1'b0;
    sync();               a = 8'h81; b = 8'h7F; i_sgn = 1'b1;
    sync();               a = 8'hFE; b = 8'h02; i_sgn = 1'b0;
    sync();
    check1("pre_rst_vld", o_vld, 1'b1);
    i_vld = 1'b0; i_rdy = 1'b0; rst_n = 1'b0;
    #1;
    check1("rst_now_vld", o_vld, 1'b0);
    check16("rst_now_res", o_res, 16'h0000);
    check1("rst_now_rdy", o_rdy, 1'b1);
    sync(); sync();
    rst_n = 1'b1; i_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check1("post_rst_no_vld", o_vld, 1'b0);
      sync();
    end

    for (int k = 0; k < 3000; k++) begin
      sync();
      i_vld = ($urandom_range(0, 3) != 0);
      a     = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      b     = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      i_sgn = 1'($urandom_range(0, 1));
      i_rdy = ($urandom_range(0, 3) != 0);
      i_clr = ($urandom_range(0, 99) == 0);
    end
    sync(); i_vld = 1'b0; i_clr = 1'b0; i_rdy = 1'b1;
    repeat (8) sync();
    @(negedge clk);
    #1;
    checki("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_nbit_wallace_pipe.md
MUL_NBIT_WALLACE_PIPE -- requirements
Module: mul_nbit_wallace_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 SHALL have parameter RES_WIDTH, default 2*DATA_WIDTH, product width; not overridden by instantiators.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_vld  input  1  upstream operand valid.
REQ-006 o_rdy  output  1  block can accept an operand pair this cycle.
REQ-007 i_num_a  input  DATA_WIDTH  multiplicand.
REQ-008 i_num_b  input  DATA_WIDTH  multiplier.
REQ-009 i_sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
REQ-010 i_clr  input  1  synchronous flush of all in-flight operations.
REQ-011 o_vld  output  1  o_res holds a valid product.
REQ-012 i_rdy  input  1  downstream accepts product.
REQ-013 o_res  output  RES_WIDTH  product.

Function
REQ-014 Operand pair SHALL be accepted on a rising edge where i_vld=1 and o_rdy=1.
REQ-015 Three register stages SHALL exist: S1 partial-product generation (DATA_WIDTH rows, sign handling per i_sgn); S2 Wallace reduction of all rows to two carry-save vectors using 1-bit full/half adders; S3 carry-propagate add into o_res.
REQ-016 Each stage SHALL carry a valid bit; o_vld is the S3 valid bit.
REQ-017 Latency SHALL be exactly 3 cycles from acceptance to o_vld=1 when no stall occurs; throughput one product per cycle.
REQ-018 Stall SHALL be global: stall = o_vld & ~i_rdy; while stalled, no stage register or valid bit changes.
REQ-019 o_rdy SHALL equal ~stall (combinational from o_vld and i_rdy).
REQ-020 A product SHALL be consumed on a rising edge where o_vld=1 and i_rdy=1; o_res and o_vld SHALL stay stable while o_vld=1 and i_rdy=0.
REQ-021 Bubbles (stage valid=0) SHALL advance like valid entries; data registers of invalid stages are don't-care but must not be presented as valid.
REQ-022 Unsigned mode: o_res SHALL equal zero-extended A times zero-extended B, exact in RES_WIDTH bits.
REQ-023 Signed mode: o_res SHALL equal sign-extended A times sign-extended B, in RES_WIDTH-bit two's complement; no overflow possible, including A=B=most-negative value.
REQ-024 Mode SHALL travel with its operand pair; mixed signed/unsigned back-to-back issues SHALL each produce their own correct result.
REQ-025 i_clr=1 SHALL clear all three valid bits on the next edge, overriding stall and any same-cycle acceptance; o_rdy is unaffected by i_clr.
REQ-026 Data registers need not be cleared by i_clr.

Reset
REQ-027 While i_rst_n=0: all stage valid bits SHALL be 0, o_vld=0, o_res=0, o_rdy=1 (irrespective of i_rdy).
REQ-028 Reset assertion mid-operation SHALL discard all in-flight products; no product from before reset SHALL ever appear.
REQ-029 First acceptance SHALL be possible on the first rising edge after i_rst_n deasserts.

Verification (DATA_WIDTH=8 unless stated)
REQ-030 Unsigned A=0xFF, B=0xFF, i_rdy=1 -> o_vld=1 exactly 3 cycles later, o_res=0xFE01.
REQ-031 Signed A=0xFF, B=0xFF -> o_res=0x0001; signed A=0x80, B=0x80 -> o_res=0x4000; signed A=0x80, B=0x01 -> o_res=0xFF80.
REQ-032 Stream 8 back-to-back pairs (A=k, B=k+1, k=0..7, alternating i_sgn) with i_rdy=1 -> 8 consecutive o_vld cycles, results in order, o_rdy held 1.
REQ-033 Fill pipeline with 3 products, hold i_rdy=0 for 5 cycles -> o_rdy=0, o_res stable at first product; release i_rdy -> remaining products delivered in order, none lost or duplicated.
REQ-034 Issue 2 pairs, assert i_clr one cycle with i_vld=1 -> no o_vld for any of those pairs; next pair after i_clr returns normally after 3 cycles.
REQ-035 Assert i_rst_n=0 with 3 in flight -> o_vld=0, o_res=0 immediately; after release, random 10k-pair regression vs reference model at DATA_WIDTH 4, 8, 16, 32, both modes, random i_rdy.
